bram_sdp: RTL and testbench
===========================

// Module: bram_sdp
// PURPOSE
//  Simple-dual-port block RAM for cipher state/key storage; successor of the single-port write-first RAM.
//  Adds byte-write enables, selectable read-during-write mode, 1- or 2-cycle read latency with valid flag,
//  and a post-reset zero-fill sequencer so no cipher round ever reads uninitialised state.
// PARAMETERS
//  word_size     32  data width in bits; must be a multiple of 8
//  addr_size     6   address width; depth = 2**addr_size
//  rd_latency    1   read latency in cycles, 1 or 2 (2 adds an output register)
//  rdw_mode      0   same-address read/write in one cycle: 0 = write-first, 1 = read-first
//  init_on_reset 1   1 = zero-fill the whole array after reset; 0 = skip the fill, ready 1 cycle after reset
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous reset, active high
//  en         in   1              port enable; read and write are accepted only when high
//  we         in   1              write enable (qualified by en)
//  be         in   word_size/8    byte enables; be[i] writes di[8i+7:8i]
//  w_addr     in   addr_size      write address
//  r_addr     in   addr_size      read address
//  di         in   word_size      write data
//  dout       out  word_size      read data
//  dout_valid out  1              dout holds a result issued rd_latency cycles earlier
//  init_busy  out  1              zero-fill in progress; all requests ignored
// BEHAVIOUR
//  Reset: dout=0, dout_valid=0, pipeline flushed. init_busy=1 if init_on_reset=1, else 0.
//  Array contents are untouched by reset except through the zero-fill.
//  FSM states: INIT -> RUN.
//   INIT: counter walks 0..2**addr_size-1, writing 0 at one address per cycle.
//    init_busy=1 throughout; en/we are ignored and no read is issued.
//    Leaves INIT after the last address: init_busy falls exactly 2**addr_size cycles after rst deasserts.
//  RUN: a request is accepted on any cycle with en=1.
//   Write: when we=1, only bytes with be[i]=1 are updated; be=0 makes the write a no-op.
//   Read: r_addr is read on every accepted cycle. dout/dout_valid are updated rd_latency cycles later.
//   en=0 issues no read: dout holds its last value and dout_valid=0 at the matching output cycle.
//   Back-to-back reads are fully pipelined at 1 result per cycle for either latency.
//   Same address, same cycle (w_addr==r_addr, we=1):
//    rdw_mode=0 returns the merged word (new bytes where be=1, old bytes elsewhere).
//    rdw_mode=1 returns the pre-write word.
//   Different addresses never interact. A write is visible to any read issued on a later cycle.
//  rst asserted mid-operation: in-flight reads are discarded (dout_valid=0 next cycle).
//   With init_on_reset=1, INIT restarts from address 0 and a partial fill simply restarts.
//  Illegal parameters (rd_latency not 1/2, word_size%8!=0) are rejected at elaboration.
// CONFIGURATION
//  BRAM_SDP_PARITY_EN defined:
//   one even-parity bit is stored per byte, and is written with that byte.
//   Extra input inj_par (1): when high on a write, the stored parity of every written byte is inverted.
//   Extra output par_err (1): valid with dout_valid; 1 if any returned byte fails its parity check.
//   Reset value of par_err is 0; the zero-fill writes correct parity.
//  BRAM_SDP_PARITY_EN undefined: no parity storage, and the ports inj_par/par_err do not exist.
// STRUCTURE
//  Package bram_pkg:
//   RDW_WRITE_FIRST=0, RDW_READ_FIRST=1
//   typedef for FSM state {INIT,RUN}
//   function byte_parity(word) returning a per-byte parity vector
//  Sub-module bram_init_seq: INIT/RUN FSM and address counter.
//   Outputs init_busy, init_we and init_addr, which are muxed onto the array write port.
//  Top level: array, byte-enable merge, RDW bypass, and the latency pipeline.
// TESTING
//  Zero-fill: rst 1 cycle, addr_size=6 -> init_busy high exactly 64 cycles; then a read of every address returns 0.
//  Byte write: write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101.
//   A later read of addr 5 returns 0xAA22CC44 with dout_valid 1 cycle later (rd_latency=1).
//  RDW: addr 3 holds 0x0; same cycle write 0xDEADBEEF (be all 1) and read addr 3.
//   rdw_mode=0 returns 0xDEADBEEF; rdw_mode=1 returns 0x00000000.
//  Pipelining: rd_latency=2, reads of addrs 0,1,2 on consecutive cycles.
//   dout_valid is high for 3 consecutive cycles starting 2 cycles later, data in order.
//   An en=0 gap produces a dout_valid=0 bubble.
//  Reset mid-fill: rst at INIT address 20.
//   The fill restarts at 0, init_busy lasts another full 64 cycles, and the pipeline shows no spurious dout_valid.
//  Parity (macro on): write 0x000000FF with inj_par=1 -> read gives par_err=1.
//   Rewriting with inj_par=0 -> par_err=0.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the bram_sdp block: read-during-write modes, the
// init sequencer state type and the per-byte parity helper.
package bram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  // Widest word the parity helper handles; callers zero-extend and truncate.
  localparam int PAR_MAX_W = 256;
  localparam int PAR_MAX_B = PAR_MAX_W / 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_t;

  // Even parity per byte: bit i is the XOR of byte i, so byte+bit has an even count of ones.
  function automatic logic [PAR_MAX_B-1:0] byte_parity(input logic [PAR_MAX_W-1:0] word);
    logic [PAR_MAX_B-1:0] p;
    for (int i = 0; i < PAR_MAX_B; i++) begin
      p[i] = ^word[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/bram_init_seq.sv
// Post-reset zero-fill sequencer for bram_sdp: walks every address once while
// init_busy is high, then parks in RUN until the next reset.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | zero-fill in progress, one address per cycle, requests ignored
// RUN   | array initialised, requests accepted
module bram_init_seq
  import bram_pkg::*;
#(
  parameter int addr_size     = 6,
  parameter int init_on_reset = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_busy,
  output logic                 init_we,
  output logic [addr_size-1:0] init_addr
);

  localparam logic [addr_size-1:0] LAST_ADDR = '1;
  localparam init_state_t RST_STATE = (init_on_reset != 0) ? INIT : RUN;

  init_state_t          r_state;
  init_state_t          w_next_state;
  logic [addr_size-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      INIT: if (r_cnt == LAST_ADDR) w_next_state = RUN;
      RUN:  w_next_state = RUN;
      default: w_next_state = RST_STATE;
    endcase
  end

  always_comb begin
    init_busy = (r_state == INIT);
    init_we   = (r_state == INIT);
    init_addr = r_cnt;
  end

  // A reset mid-fill restarts the walk from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == INIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM with byte enables, selectable read-during-write, 1/2-cycle
// read latency and post-reset zero-fill. Optional byte parity: BRAM_SDP_PARITY_EN.
module bram_sdp
  import bram_pkg::*;
#(
  parameter int word_size     = 32,
  parameter int addr_size     = 6,
  parameter int rd_latency    = 1,
  parameter int rdw_mode      = 0,
  parameter int init_on_reset = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   we,
  input  logic [word_size/8-1:0] be,
  input  logic [addr_size-1:0]   w_addr,
  input  logic [addr_size-1:0]   r_addr,
  input  logic [word_size-1:0]   di,
  output logic [word_size-1:0]   dout,
  output logic                   dout_valid,
  output logic                   init_busy
`ifdef BRAM_SDP_PARITY_EN
  ,
  input  logic                   inj_par,
  output logic                   par_err
`endif
);

  localparam int NB    = word_size / 8;
  localparam int DEPTH = 1 << addr_size;

  if (rd_latency != 1 && rd_latency != 2) begin : g_bad_latency
    $error("bram_sdp: rd_latency must be 1 or 2");
  end
  if ((word_size % 8) != 0 || word_size < 8) begin : g_bad_width
    $error("bram_sdp: word_size must be a non-zero multiple of 8");
  end

  logic                 w_init_we;
  logic [addr_size-1:0] w_init_addr;

  bram_init_seq #(
    .addr_size    (addr_size),
    .init_on_reset(init_on_reset)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy),
    .init_we  (w_init_we),
    .init_addr(w_init_addr)
  );

  // Write port: the fill sequencer owns it while busy, the user port otherwise.
  logic                 w_wr_en;
  logic [addr_size-1:0] w_wr_addr;
  logic [word_size-1:0] w_wr_data;
  logic [NB-1:0]        w_wr_be;
  logic                 w_rd_en;

  assign w_wr_en   = init_busy ? w_init_we : (en && we && !rst);
  assign w_wr_addr = init_busy ? w_init_addr : w_addr;
  assign w_wr_data = init_busy ? '0 : di;
  assign w_wr_be   = init_busy ? '1 : be;
  assign w_rd_en   = en && !init_busy && !rst;

  logic [word_size-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (w_wr_be[i]) r_mem[w_wr_addr][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  logic [word_size-1:0] w_old;
  logic [word_size-1:0] w_merged;
  logic                 w_same;
  logic                 w_bypass;
  logic [word_size-1:0] w_rd_word;

  assign w_old    = r_mem[r_addr];
  assign w_same   = w_wr_en && (w_wr_addr == r_addr);
  assign w_bypass = (rdw_mode == RDW_WRITE_FIRST) && w_same;

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NB; i++) begin
      if (w_wr_be[i]) w_merged[8*i +: 8] = w_wr_data[8*i +: 8];
    end
  end

  assign w_rd_word = w_bypass ? w_merged : w_old;

`ifdef BRAM_SDP_PARITY_EN
  if (word_size > PAR_MAX_W) begin : g_bad_par_width
    $error("bram_sdp: word_size too wide for the parity helper");
  end

  logic [NB-1:0]        r_par [DEPTH];
  logic [PAR_MAX_B-1:0] w_wr_par_full;
  logic [PAR_MAX_B-1:0] w_rd_chk_full;
  logic [NB-1:0]        w_wr_par;
  logic [NB-1:0]        w_old_par;
  logic [NB-1:0]        w_par_merged;
  logic [NB-1:0]        w_rd_par;
  logic                 w_rd_perr;

  // inj_par flips the stored bit of each written byte; the fill always writes good parity.
  assign w_wr_par_full = byte_parity(PAR_MAX_W'(w_wr_data));
  assign w_wr_par      = w_wr_par_full[NB-1:0] ^ {NB{inj_par && !init_busy}};
  assign w_old_par     = r_par[r_addr];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (w_wr_be[i]) r_par[w_wr_addr][i] <= w_wr_par[i];
      end
    end
  end

  always_comb begin
    w_par_merged = w_old_par;
    for (int i = 0; i < NB; i++) begin
      if (w_wr_be[i]) w_par_merged[i] = w_wr_par[i];
    end
  end

  assign w_rd_par      = w_bypass ? w_par_merged : w_old_par;
  assign w_rd_chk_full = byte_parity(PAR_MAX_W'(w_rd_word));
  assign w_rd_perr     = |(w_rd_chk_full[NB-1:0] ^ w_rd_par);
`endif

  // Stage 1: data only advances on an accepted read so dout holds across en=0 gaps.
  logic [word_size-1:0] r_s1_data;
  logic                 r_s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_en;
      if (w_rd_en) r_s1_data <= w_rd_word;
    end
  end

`ifdef BRAM_SDP_PARITY_EN
  logic r_s1_perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_perr <= 1'b0;
    end else if (w_rd_en) begin
      r_s1_perr <= w_rd_perr;
    end
  end
`endif

  if (rd_latency == 2) begin : g_lat2
    logic [word_size-1:0] r_s2_data;
    logic                 r_s2_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_data  <= '0;
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_s2_data <= r_s1_data;
      end
    end

    assign dout       = r_s2_data;
    assign dout_valid = r_s2_valid;

`ifdef BRAM_SDP_PARITY_EN
    logic r_s2_perr;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_perr <= 1'b0;
      end else if (r_s1_valid) begin
        r_s2_perr <= r_s1_perr;
      end
    end

    assign par_err = r_s2_perr;
`endif
  end else begin : g_lat1
    assign dout       = r_s1_data;
    assign dout_valid = r_s1_valid;
`ifdef BRAM_SDP_PARITY_EN
    assign par_err    = r_s1_perr;
`endif
  end

endmodule

// File: tb/tb_bram_sdp.sv
// Directed self-checking bench for bram_sdp: four instances share one stimulus
// (write-first/1-cycle, read-first/1-cycle, write-first/2-cycle, no zero-fill).
module tb_bram_sdp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        we;
  logic [3:0]  be;
  logic [5:0]  w_addr;
  logic [5:0]  r_addr;
  logic [31:0] di;

  logic [31:0] dout_a, dout_b, dout_c, dout_d;
  logic        val_a, val_b, val_c, val_d;
  logic        busy_a, busy_b, busy_c, busy_d;
`ifdef BRAM_SDP_PARITY_EN
  logic        inj_par;
  logic        perr_a, perr_b, perr_c, perr_d;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bram_sdp #(.rd_latency(1), .rdw_mode(0), .init_on_reset(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .w_addr(w_addr), .r_addr(r_addr),
    .di(di), .dout(dout_a), .dout_valid(val_a), .init_busy(busy_a)
`ifdef BRAM_SDP_PARITY_EN
    , .inj_par(inj_par), .par_err(perr_a)
`endif
  );

  bram_sdp #(.rd_latency(1), .rdw_mode(1), .init_on_reset(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .w_addr(w_addr), .r_addr(r_addr),
    .di(di), .dout(dout_b), .dout_valid(val_b), .init_busy(busy_b)
`ifdef BRAM_SDP_PARITY_EN
    , .inj_par(inj_par), .par_err(perr_b)
`endif
  );

  bram_sdp #(.rd_latency(2), .rdw_mode(0), .init_on_reset(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .w_addr(w_addr), .r_addr(r_addr),
    .di(di), .dout(dout_c), .dout_valid(val_c), .init_busy(busy_c)
`ifdef BRAM_SDP_PARITY_EN
    , .inj_par(inj_par), .par_err(perr_c)
`endif
  );

  bram_sdp #(.rd_latency(1), .rdw_mode(0), .init_on_reset(0)) dut_d (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .w_addr(w_addr), .r_addr(r_addr),
    .di(di), .dout(dout_d), .dout_valid(val_d), .init_busy(busy_d)
`ifdef BRAM_SDP_PARITY_EN
    , .inj_par(inj_par), .par_err(perr_d)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    n_tests++;
    if (dout_a !== 32'h0 || val_a !== 1'b0 || val_c !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: dout=%h valid=%b valid_l2=%b, want 0/0/0", dout_a, val_a, val_c);
    end
    n_tests++;
    if (busy_a !== 1'b1 || busy_d !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: busy=%b busy_noinit=%b, want 1/0", busy_a, busy_d);
    end
`ifdef BRAM_SDP_PARITY_EN
    n_tests++;
    if (perr_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_par_err: got %b want 0", perr_a);
    end
`endif
    rst = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL fill_length: init_busy high %0d cycles, want 64", n);
    end
    n_tests++;
    if (busy_d !== 1'b0) begin
      n_fail++;
      $display("FAIL noinit_busy: got %b want 0", busy_d);
    end
  endtask

  task automatic test_zero_fill();
    en = 1'b1;
    we = 1'b0;
    for (int a = 0; a < 64; a++) begin
      r_addr = 6'(a);
      tick();
      n_tests++;
      if (dout_a !== 32'h0 || val_a !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_fill[%0d]: dout=%h valid=%b, want 00000000/1", a, dout_a, val_a);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_byte_write();
    en = 1'b1; we = 1'b1; w_addr = 6'd5; be = 4'b1111; di = 32'hAABBCCDD; r_addr = 6'd10;
    tick();
    n_tests++;
    if (dout_a !== 32'h0) begin
      n_fail++;
      $display("FAIL other_addr: got %h want 00000000", dout_a);
    end
    di = 32'h11223344; be = 4'b0101;
    tick();
    we = 1'b0; r_addr = 6'd5;
    tick();
    n_tests++;
    if (dout_a !== 32'hAA22CC44 || val_a !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_merge: dout=%h valid=%b, want aa22cc44/1", dout_a, val_a);
    end
    we = 1'b1; be = 4'b0000; di = 32'hFFFFFFFF;
    tick();
    we = 1'b0;
    tick();
    n_tests++;
    if (dout_a !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL be_zero_noop: got %h want aa22cc44", dout_a);
    end
  endtask

  task automatic test_rdw();
    en = 1'b1; we = 1'b1; be = 4'b1111; w_addr = 6'd3; r_addr = 6'd3; di = 32'hDEADBEEF;
    tick();
    n_tests++;
    if (dout_a !== 32'hDEADBEEF || dout_b !== 32'h0) begin
      n_fail++;
      $display("FAIL rdw_full: wf=%h rf=%h, want deadbeef/00000000", dout_a, dout_b);
    end
    di = 32'h11111111; be = 4'b0011;
    tick();
    n_tests++;
    if (dout_a !== 32'hDEAD1111 || dout_b !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rdw_partial: wf=%h rf=%h, want dead1111/deadbeef", dout_a, dout_b);
    end
    n_tests++;
    if (dout_c !== 32'hDEADBEEF || val_c !== 1'b1) begin
      n_fail++;
      $display("FAIL rdw_lat2: dout=%h valid=%b, want deadbeef/1", dout_c, val_c);
    end
    en = 1'b0; we = 1'b0;
    tick();
    n_tests++;
    if (dout_a !== 32'hDEAD1111 || val_a !== 1'b0) begin
      n_fail++;
      $display("FAIL en_low_hold: dout=%h valid=%b, want dead1111/0", dout_a, val_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [7];
    logic        exp_v [7];
    logic        en_seq [7];
    logic [5:0]  addr_seq [7];
    exp_v = '{0, 1, 1, 1, 0, 1, 0};
    exp_d = '{32'h0, 32'h100, 32'h101, 32'h102, 32'h102, 32'h100, 32'h100};
    en_seq = '{1, 1, 1, 0, 1, 0, 0};
    addr_seq = '{6'd0, 6'd1, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0};
    en = 1'b1; we = 1'b1; be = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      w_addr = 6'(i); r_addr = 6'(i); di = 32'h100 + 32'(i);
      tick();
    end
    en = 1'b0; we = 1'b0;
    tick();
    tick();
    for (int t = 0; t < 7; t++) begin
      en = en_seq[t]; r_addr = addr_seq[t];
      tick();
      n_tests++;
      if (val_c !== exp_v[t] || (exp_v[t] && dout_c !== exp_d[t]) || (t == 4 && dout_c !== exp_d[t])) begin
        n_fail++;
        $display("FAIL pipe_lat2[%0d]: dout=%h valid=%b, want %h/%b", t, dout_c, val_c, exp_d[t], exp_v[t]);
      end
    end
    n_tests++;
    if (val_a !== 1'b0 || dout_a !== 32'h100) begin
      n_fail++;
      $display("FAIL pipe_lat1_tail: dout=%h valid=%b, want 00000100/0", dout_a, val_a);
    end
  endtask

`ifdef BRAM_SDP_PARITY_EN
  task automatic test_parity();
    en = 1'b1; we = 1'b1; be = 4'b1111; w_addr = 6'd9; r_addr = 6'd20; di = 32'h000000FF; inj_par = 1'b1;
    tick();
    we = 1'b0; inj_par = 1'b0; r_addr = 6'd9;
    tick();
    n_tests++;
    if (perr_a !== 1'b1 || dout_a !== 32'h000000FF) begin
      n_fail++;
      $display("FAIL par_inject: par_err=%b dout=%h, want 1/000000ff", perr_a, dout_a);
    end
    we = 1'b1; r_addr = 6'd20;
    tick();
    we = 1'b0; r_addr = 6'd9;
    tick();
    n_tests++;
    if (perr_a !== 1'b0) begin
      n_fail++;
      $display("FAIL par_clean: par_err=%b want 0", perr_a);
    end
    en = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_fill();
    int n;
    logic spurious;
    en = 1'b1; we = 1'b0; r_addr = 6'd5;
    tick();
    rst = 1'b1; we = 1'b1; w_addr = 6'd2; be = 4'b1111; di = 32'hFFFFFFFF;
    tick();
    n_tests++;
    if (val_a !== 1'b0 || val_c !== 1'b0 || dout_a !== 32'h0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_flush: valid=%b valid_l2=%b dout=%h busy=%b, want 0/0/0/1", val_a, val_c, dout_a, busy_a);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    n_tests++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_fill_busy: got %b want 1", busy_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    spurious = 1'b0;
    while (busy_a === 1'b1 && n < 200) begin
      if (val_a !== 1'b0 || val_c !== 1'b0) spurious = 1'b1;
      tick();
      n++;
    end
    we = 1'b0;
    n_tests++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL refill_length: init_busy high %0d cycles, want 64", n);
    end
    n_tests++;
    if (spurious !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_valid: dout_valid seen during fill, want none");
    end
    r_addr = 6'd2;
    tick();
    n_tests++;
    if (dout_a !== 32'h0) begin
      n_fail++;
      $display("FAIL fill_ignores_write: addr2=%h want 00000000", dout_a);
    end
    r_addr = 6'd5;
    tick();
    n_tests++;
    if (dout_a !== 32'h0) begin
      n_fail++;
      $display("FAIL refill_zero: addr5=%h want 00000000", dout_a);
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; be = 4'b0; w_addr = '0; r_addr = '0; di = '0;
`ifdef BRAM_SDP_PARITY_EN
    inj_par = 1'b0;
`endif
    test_reset();
    test_zero_fill();
    test_byte_write();
    test_rdw();
    test_back_to_back();
`ifdef BRAM_SDP_PARITY_EN
    test_parity();
`endif
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
